// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad key codes, scan states and row/col to key-bit mapping
package keypad_pkg;

    localparam int KEY_0    = 0;
    localparam int KEY_1    = 1;
    localparam int KEY_2    = 2;
    localparam int KEY_3    = 3;
    localparam int KEY_4    = 4;
    localparam int KEY_5    = 5;
    localparam int KEY_6    = 6;
    localparam int KEY_7    = 7;
    localparam int KEY_8    = 8;
    localparam int KEY_9    = 9;
    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        SCAN_R0,
        SCAN_R1,
        SCAN_R2,
        SCAN_R3
    } scan_state_t;

    // Rows 0-2 hold digits 1-9 in reading order; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        if (row == 2'd3) begin
            case (col)
                2'd0:    idx = 4'(KEY_STAR);
                2'd1:    idx = 4'(KEY_0);
                default: idx = 4'(KEY_HASH);
            endcase
        end else begin
            idx = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized-width two-flop synchronizer with async reset value
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with frame debounce and one-hot output
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  row_n,
    input  logic [2:0]  col_n,
    output logic [11:0] keyOneHot,
    output logic        keyPress
);

    localparam int         DIV_W = $clog2(SCAN_DIV);
    localparam logic [3:0] DEB   = 4'(DEBOUNCE_CNT);

    logic [2:0]          col_sync;
    logic [2:0]          col_s;
    logic [DIV_W-1:0]    div_cnt;
    scan_state_t         state;
    logic [NUM_KEYS-1:0] frame;
    logic [NUM_KEYS-1:0] frame_full;
    logic [NUM_KEYS-1:0] prev_frame;
    logic [NUM_KEYS-1:0] commit_val;
    logic [3:0]          stable_cnt;
    logic                commit_pending;
    logic                sample;

    sync_2ff #(
        .WIDTH     (3),
        .RESET_VAL (3'b111)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_n),
        .q     (col_sync)
    );

    assign col_s  = ~col_sync;
    assign sample = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // Frame as seen at the row-3 sample edge, with row 3 taken live from the synchronizer.
    always_comb begin
        frame_full = frame;
        for (int c = 0; c < NUM_COLS; c++) begin
            frame_full[key_index(2'd3, 2'(c))] = col_s[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= SCAN_R0;
            row_n          <= 4'b1110;
            div_cnt        <= '0;
            frame          <= '0;
            prev_frame     <= '0;
            commit_val     <= '0;
            stable_cnt     <= '0;
            commit_pending <= 1'b0;
            keyOneHot      <= '0;
            keyPress       <= 1'b0;
        end else begin
            commit_pending <= 1'b0;
            keyPress       <= 1'b0;
            if (commit_pending) begin
                keyOneHot <= commit_val;
                keyPress  <= (commit_val != '0) && (commit_val != keyOneHot);
            end

            if (sample) begin
                div_cnt <= '0;
                for (int c = 0; c < NUM_COLS; c++) begin
                    frame[key_index(state, 2'(c))] <= col_s[c];
                end
                case (state)
                    SCAN_R0: begin
                        state <= SCAN_R1;
                        row_n <= 4'b1101;
                    end
                    SCAN_R1: begin
                        state <= SCAN_R2;
                        row_n <= 4'b1011;
                    end
                    SCAN_R2: begin
                        state <= SCAN_R3;
                        row_n <= 4'b0111;
                    end
                    default: begin
                        state <= SCAN_R0;
                        row_n <= 4'b1110;
                        if (frame_full != prev_frame) begin
                            stable_cnt <= '0;
                            prev_frame <= frame_full;
                        end else begin
                            if (stable_cnt < DEB) begin
                                stable_cnt <= stable_cnt + 4'd1;
                            end
                            // Commit once the count reaches the threshold, and re-commit while saturated.
                            if (stable_cnt >= DEB - 4'd1) begin
                                commit_pending <= 1'b1;
                                commit_val     <= ($countones(frame_full) == 1) ? frame_full : '0;
                            end
                        end
                    end
                endcase
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_n;
    logic [2:0]  col_n;
    logic [11:0] keyOneHot;
    logic        keyPress;
    logic [11:0] pressed;

    int passes = 0;
    int total  = 0;
    int pulses = 0;
    int cyc    = 0;
    int last_pulse = 0;

    int key_table [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .keyOneHot (keyOneHot),
        .keyPress  (keyPress)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_n[r] && pressed[key_table[r][c]]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_watch();
        pulses     = 0;
        cyc        = 0;
        last_pulse = 0;
    endtask

    task automatic step_watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (keyPress === 1'b1) begin
                pulses++;
                last_pulse = cyc;
            end
        end
    endtask

    task automatic wait_frame_start();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = row_n;
        for (int i = 0; i < 24 && !found; i++) begin
            @(posedge clk);
            #1;
            if (row_n == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = row_n;
        end
        check("frame_sync", 32'(found), 32'd1);
    endtask

    task automatic press_commit(input string tag, input logic [11:0] val);
        wait_frame_start();
        pressed = val;
        clear_watch();
        step_watch(64);
        check({tag, "_before"}, 32'(keyOneHot), 32'h0);
        step_watch(1);
        check({tag, "_val"}, 32'(keyOneHot), 32'(val));
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_latency"}, last_pulse, 65);
    endtask

    task automatic release_all(input string tag, input logic [11:0] old);
        wait_frame_start();
        pressed = '0;
        clear_watch();
        step_watch(64);
        check({tag, "_held"}, 32'(keyOneHot), 32'(old));
        step_watch(1);
        check({tag, "_zero"}, 32'(keyOneHot), 32'h0);
        check({tag, "_nopulse"}, pulses, 0);
    endtask

    logic [3:0]  exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [11:0] special  [3] = '{12'h400, 12'h001, 12'h800};

    initial begin
        reset   = 1'b1;
        pressed = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_row_n", 32'(row_n), 32'hE);
        check("rst_key", 32'(keyOneHot), 32'h0);
        check("rst_press", 32'(keyPress), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(posedge clk);
            #1;
            check("row_cycle", 32'(row_n), 32'(exp_rows[k]));
        end
        clear_watch();
        step_watch(64);
        check("idle_key", 32'(keyOneHot), 32'h0);
        check("idle_pulses", pulses, 0);

        press_commit("key5", 12'h020);
        clear_watch();
        step_watch(40);
        check("key5_hold", 32'(keyOneHot), 32'h020);
        check("key5_hold_nopulse", pulses, 0);
        release_all("key5_rel", 12'h020);

        for (int k = 0; k < 3; k++) begin
            press_commit("special", special[k]);
            release_all("special_rel", special[k]);
        end

        wait_frame_start();
        clear_watch();
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 12'h080 : 12'h000;
            step_watch(16);
        end
        check("bounce_key", 32'(keyOneHot), 32'h0);
        check("bounce_pulses", pulses, 0);
        pressed = 12'h080;
        clear_watch();
        step_watch(65);
        check("key7_val", 32'(keyOneHot), 32'h080);
        check("key7_pulses", pulses, 1);
        check("key7_latency", last_pulse, 65);
        release_all("key7_rel", 12'h080);

        wait_frame_start();
        pressed = 12'h202;
        clear_watch();
        step_watch(100);
        check("multi_1_9_key", 32'(keyOneHot), 32'h0);
        check("multi_1_9_pulses", pulses, 0);
        release_all("multi_rel", 12'h000);

        press_commit("key3", 12'h008);
        wait_frame_start();
        pressed = 12'h048;
        clear_watch();
        step_watch(64);
        check("add6_held", 32'(keyOneHot), 32'h008);
        step_watch(1);
        check("add6_key", 32'(keyOneHot), 32'h0);
        check("add6_pulses", pulses, 0);
        wait_frame_start();
        pressed = 12'h008;
        clear_watch();
        step_watch(65);
        check("rel6_key", 32'(keyOneHot), 32'h008);
        check("rel6_pulses", pulses, 1);
        wait_frame_start();
        pressed = 12'h040;
        clear_watch();
        step_watch(65);
        check("a_to_b_key", 32'(keyOneHot), 32'h040);
        check("a_to_b_pulses", pulses, 1);
        check("a_to_b_latency", last_pulse, 65);
        release_all("key6_rel", 12'h040);

        press_commit("key2", 12'h004);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("hold_rst_key", 32'(keyOneHot), 32'h0);
        check("hold_rst_row", 32'(row_n), 32'hE);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_watch();
        step_watch(64);
        check("recommit_before", 32'(keyOneHot), 32'h0);
        step_watch(1);
        check("recommit_key", 32'(keyOneHot), 32'h004);
        check("recommit_pulses", pulses, 1);
        check("recommit_latency", last_pulse, 65);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
